// File: rtl/blast_map_writer_pkg.sv
// Shared types for the blast map writer: tile codes, blast directions, FSM states,
// and default map geometry.
package blast_map_writer_pkg;

  localparam int unsigned MAP_NUM_ROW_DEF   = 11;
  localparam int unsigned MAP_NUM_COL_DEF   = 19;
  localparam int unsigned MAP_MEM_WIDTH_DEF = 2;
  localparam int unsigned MAX_RADIUS_DEF    = 7;

  typedef enum logic [1:0] {
    TileNoBlk   = 2'd0,
    TilePermBlk = 2'd1,
    TileDestBlk = 2'd2,
    TileBomb    = 2'd3
  } tile_t;

  // Order matters: blast arms are walked in this order.
  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    StIdle,
    StPlace,
    StCenter,
    StStep,
    StWait,
    StEval,
    StDone
  } blast_state_t;

endpackage

// File: rtl/blast_map_writer_if.sv
// Request and map-port bundle of the blast map writer.
//   master: bomb controller / map memory side (drives requests and rd_data)
//   slave : the writer itself (drives acks, flame/chain reports and the map port)
interface blast_map_writer_if import blast_map_writer_pkg::*; #(
  parameter int unsigned NUM_ROW    = MAP_NUM_ROW_DEF,
  parameter int unsigned NUM_COL    = MAP_NUM_COL_DEF,
  parameter int unsigned DATA_WIDTH = MAP_MEM_WIDTH_DEF,
  parameter int unsigned MAX_RADIUS = MAX_RADIUS_DEF
);
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL);
  localparam int unsigned RW         = $clog2(NUM_ROW);
  localparam int unsigned CW         = $clog2(NUM_COL);
  localparam int unsigned RADW       = $clog2(MAX_RADIUS + 1);

  logic                  game_over;
  logic                  place_req;
  logic [ADDR_WIDTH-1:0] place_addr;
  logic                  place_ack;
  logic                  blast_req;
  logic [RW-1:0]         blast_row;
  logic [CW-1:0]         blast_col;
  logic [RADW-1:0]       blast_radius;
  logic                  busy;
  logic                  done;
  logic                  flame_valid;
  logic [ADDR_WIDTH-1:0] flame_addr;
  logic                  chain_valid;
  logic [ADDR_WIDTH-1:0] chain_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output game_over, place_req, place_addr, blast_req, blast_row, blast_col, blast_radius,
           rd_data,
    input  place_ack, busy, done, flame_valid, flame_addr, chain_valid, chain_addr, rd_addr,
           we, wr_addr, wr_data
  );

  modport slave (
    input  game_over, place_req, place_addr, blast_req, blast_row, blast_col, blast_radius,
           rd_data,
    output place_ack, busy, done, flame_valid, flame_addr, chain_valid, chain_addr, rd_addr,
           we, wr_addr, wr_data
  );

endinterface

// File: rtl/blast_map_writer_tile_step.sv
// Combinational blast-arm geometry: target tile = centre + step * dir.
//   row, col   : blast centre
//   dir, step  : arm direction and distance from the centre
//   addr       : row*NUM_COL + col of the target (0 when out of bounds)
//   in_bounds  : target lies on the map
module blast_map_writer_tile_step import blast_map_writer_pkg::*; #(
  parameter int unsigned NUM_ROW    = MAP_NUM_ROW_DEF,
  parameter int unsigned NUM_COL    = MAP_NUM_COL_DEF,
  parameter int unsigned MAX_RADIUS = MAX_RADIUS_DEF,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL),
  localparam int unsigned RW         = $clog2(NUM_ROW),
  localparam int unsigned CW         = $clog2(NUM_COL),
  localparam int unsigned RADW       = $clog2(MAX_RADIUS + 1)
) (
  input  logic [RW-1:0]         row,
  input  logic [CW-1:0]         col,
  input  dir_t                  dir,
  input  logic [RADW-1:0]       step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_bounds
);

  // Signed work width: largest coordinate plus largest step must not wrap, plus sign.
  localparam int unsigned CoordW = (RW > CW) ? RW : CW;
  localparam int unsigned SW     = ((CoordW > RADW) ? CoordW : RADW) + 2;

  logic signed [SW-1:0] row_s, col_s, step_s, tgt_row, tgt_col;
  logic [SW-1:0]        tgt_row_u, tgt_col_u;

  always_comb begin
    row_s   = $signed(SW'(row));
    col_s   = $signed(SW'(col));
    step_s  = $signed(SW'(step));
    tgt_row = row_s;
    tgt_col = col_s;
    unique case (dir)
      DirUp:    tgt_row = row_s - step_s;
      DirDown:  tgt_row = row_s + step_s;
      DirLeft:  tgt_col = col_s - step_s;
      DirRight: tgt_col = col_s + step_s;
      default:  ;
    endcase
    in_bounds = !tgt_row[SW-1] && (tgt_row < $signed(SW'(NUM_ROW))) &&
                !tgt_col[SW-1] && (tgt_col < $signed(SW'(NUM_COL)));
    tgt_row_u = $unsigned(tgt_row);
    tgt_col_u = $unsigned(tgt_col);
    addr = in_bounds ? ADDR_WIDTH'(32'(tgt_row_u) * NUM_COL + 32'(tgt_col_u)) : '0;
  end

endmodule

// File: rtl/blast_map_writer.sv
// Sole owner of the tile map write port. Places bombs, and for a detonation walks the
// blast cross (up, down, left, right) through the registered read port, clearing
// destroyable blocks, reporting flame tiles and flagging hit bombs for chaining.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requests, flame/chain reports and map read/write port (slave side)
module blast_map_writer import blast_map_writer_pkg::*; #(
  parameter int unsigned NUM_ROW    = MAP_NUM_ROW_DEF,
  parameter int unsigned NUM_COL    = MAP_NUM_COL_DEF,
  parameter int unsigned DATA_WIDTH = MAP_MEM_WIDTH_DEF,
  parameter int unsigned MAX_RADIUS = MAX_RADIUS_DEF
) (
  input logic               clk,
  input logic               rst_n,
  blast_map_writer_if.slave bus
);

  localparam int unsigned ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL);
  localparam int unsigned RW         = $clog2(NUM_ROW);
  localparam int unsigned CW         = $clog2(NUM_COL);
  localparam int unsigned RADW       = $clog2(MAX_RADIUS + 1);

  blast_state_t          state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RADW-1:0]       radius_q, radius_d, step_q, step_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] centre_addr, target_addr;
  logic                  target_in_bounds;
  logic                  advance;

  blast_map_writer_tile_step #(
    .NUM_ROW    (NUM_ROW),
    .NUM_COL    (NUM_COL),
    .MAX_RADIUS (MAX_RADIUS)
  ) u_tile_step (
    .row       (row_q),
    .col       (col_q),
    .dir       (dir_q),
    .step      (step_q),
    .addr      (target_addr),
    .in_bounds (target_in_bounds)
  );

  assign centre_addr = ADDR_WIDTH'(32'(row_q) * NUM_COL + 32'(col_q));
  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = (state_q != StIdle) && (state_q != StPlace);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dir_q     <= DirUp;
      row_q     <= '0;
      col_q     <= '0;
      radius_q  <= '0;
      step_q    <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      row_q     <= row_d;
      col_q     <= col_d;
      radius_q  <= radius_d;
      step_q    <= step_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    dir_d           = dir_q;
    row_d           = row_q;
    col_d           = col_q;
    radius_d        = radius_q;
    step_d          = step_q;
    rd_addr_d       = rd_addr_q;
    advance         = 1'b0;
    bus.place_ack   = 1'b0;
    bus.done        = 1'b0;
    bus.flame_valid = 1'b0;
    bus.flame_addr  = '0;
    bus.chain_valid = 1'b0;
    bus.chain_addr  = '0;
    bus.we          = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;

    unique case (state_q)
      StIdle: begin
        // Blast wins a tie; a held place_req is picked up once the blast is done.
        if (bus.blast_req) begin
          state_d  = StCenter;
          row_d    = bus.blast_row;
          col_d    = bus.blast_col;
          radius_d = (bus.blast_radius == '0) ? RADW'(1) : bus.blast_radius;
        end else if (bus.place_req) begin
          state_d = StPlace;
        end
      end
      StPlace: begin
        bus.we        = 1'b1;
        bus.wr_addr   = bus.place_addr;
        bus.wr_data   = DATA_WIDTH'(TileBomb);
        bus.place_ack = 1'b1;
        state_d       = StIdle;
      end
      StCenter: begin
        // The detonating bomb removes itself.
        bus.we          = 1'b1;
        bus.wr_addr     = centre_addr;
        bus.wr_data     = DATA_WIDTH'(TileNoBlk);
        bus.flame_valid = 1'b1;
        bus.flame_addr  = centre_addr;
        dir_d           = DirUp;
        step_d          = RADW'(1);
        state_d         = StStep;
      end
      StStep: begin
        if (target_in_bounds) begin
          rd_addr_d = target_addr;
          state_d   = StWait;
        end else begin
          advance = 1'b1;
        end
      end
      StWait: state_d = StEval;
      StEval: begin
        case (bus.rd_data)
          DATA_WIDTH'(TileNoBlk): begin
            bus.flame_valid = 1'b1;
            bus.flame_addr  = target_addr;
            if (step_q < radius_q) begin
              step_d  = step_q + RADW'(1);
              state_d = StStep;
            end else begin
              advance = 1'b1;
            end
          end
          DATA_WIDTH'(TileDestBlk): begin
            bus.we          = 1'b1;
            bus.wr_addr     = target_addr;
            bus.wr_data     = DATA_WIDTH'(TileNoBlk);
            bus.flame_valid = 1'b1;
            bus.flame_addr  = target_addr;
            advance         = 1'b1;
          end
          DATA_WIDTH'(TileBomb): begin
            // Left in place: the chained blast clears its own tile.
            bus.flame_valid = 1'b1;
            bus.flame_addr  = target_addr;
            bus.chain_valid = 1'b1;
            bus.chain_addr  = target_addr;
            advance         = 1'b1;
          end
          default: advance = 1'b1;
        endcase
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      step_d = RADW'(1);
      if (dir_q == DirRight) begin
        state_d = StDone;
      end else begin
        dir_d   = dir_t'(dir_q + 2'd1);
        state_d = StStep;
      end
    end

    // Map is being reinitialised: drop everything, no done pulse.
    if (bus.game_over) begin
      state_d         = StIdle;
      bus.place_ack   = 1'b0;
      bus.done        = 1'b0;
      bus.flame_valid = 1'b0;
      bus.chain_valid = 1'b0;
      bus.we          = 1'b0;
    end
  end

endmodule
